// File: rtl/countdown_timer.sv
// MM:SS.hh BCD countdown timer. A prescaler divides the clock into 10 ms ticks.
// Each tick decrements the six-digit BCD value through a borrow chain.

module countdown_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] val_i,
  input  logic       borrow_i,
  input  logic [3:0] preset_i,
  output logic [3:0] dec_o,
  output logic       borrow_o,
  output logic [3:0] sat_o
);
  always_comb begin
    dec_o    = val_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (val_i == 4'd0) begin
        dec_o    = MAX;
        borrow_o = 1'b1;
      end else begin
        dec_o = val_i - 4'd1;
      end
    end
  end

  assign sat_o = (preset_i > MAX) ? MAX : preset_i;
endmodule

module countdown_timer #(
  parameter int unsigned DELAY = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset_min_higher,
  input  logic [3:0] preset_min_lower,
  input  logic [3:0] preset_s_higher,
  input  logic [3:0] preset_s_lower,
  output logic [3:0] min_higher,
  output logic [3:0] min_lower,
  output logic [3:0] s_higher,
  output logic [3:0] s_lower,
  output logic [3:0] ms_higher,
  output logic [3:0] ms_lower,
  output logic       running,
  output logic       done,
  output logic       expired
);
  localparam int unsigned    NUM_DIG = 6;
  localparam int unsigned    PW      = $clog2(DELAY);
  localparam logic [PW-1:0]  LAST    = PW'(DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXP} state_t;

  state_t                         state_q, state_d;
  logic [NUM_DIG-1:0][3:0]        dig_q, dig_d, dig_dec, dig_sat, preset;
  logic [NUM_DIG:0]               borrow;
  logic [PW-1:0]                  presc_q, presc_d;
  logic                           done_q, done_d;
  logic                           running_q, expired_q;
  logic                           tick, is_zero, dec_zero;

  // Digit 0 is hundredths; the ms digits always load as zero.
  assign preset    = {preset_min_higher, preset_min_lower,
                      preset_s_higher, preset_s_lower, 8'h00};
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    localparam logic [3:0] DMAX = (i == 3 || i == 5) ? 4'd5 : 4'd9;
    countdown_digit #(.MAX(DMAX)) u_dig (
      .val_i    (dig_q[i]),
      .borrow_i (borrow[i]),
      .preset_i (preset[i]),
      .dec_o    (dig_dec[i]),
      .borrow_o (borrow[i+1]),
      .sat_o    (dig_sat[i])
    );
  end

  // A borrow out of the top digit means every digit is zero.
  assign is_zero  = borrow[NUM_DIG];
  assign dec_zero = (dig_dec == '0);
  assign tick     = (presc_q == LAST);

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_PAUSE: begin
        if (load) begin
          dig_d   = dig_sat;
          presc_d = '0;
          state_d = S_IDLE;
        end else if (start && !stop && !is_zero) begin
          presc_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The expiring tick beats a simultaneous stop.
        if (tick && dec_zero) begin
          dig_d   = dig_dec;
          presc_d = '0;
          done_d  = 1'b1;
          state_d = S_EXP;
        end else if (stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          dig_d   = dig_dec;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_EXP: begin
        if (load) begin
          dig_d   = dig_sat;
          presc_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      dig_q     <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
      expired_q <= (state_d == S_EXP);
    end
  end

  assign min_higher = dig_q[5];
  assign min_lower  = dig_q[4];
  assign s_higher   = dig_q[3];
  assign s_lower    = dig_q[2];
  assign ms_higher  = dig_q[1];
  assign ms_lower   = dig_q[0];
  assign running    = running_q;
  assign done       = done_q;
  assign expired    = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with DELAY=4 (one tick every 4 cycles).
module tb_countdown_timer;
  logic       clock, reset_n, load, start, stop;
  logic [3:0] p_mh, p_ml, p_sh, p_sl;
  logic [3:0] min_higher, min_lower, s_higher, s_lower, ms_higher, ms_lower;
  logic       running, done, expired;
  logic [23:0] disp;
  int checks = 0;
  int errors = 0;

  countdown_timer #(.DELAY(4)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .start(start), .stop(stop),
    .preset_min_higher(p_mh), .preset_min_lower(p_ml),
    .preset_s_higher(p_sh), .preset_s_lower(p_sl),
    .min_higher(min_higher), .min_lower(min_lower),
    .s_higher(s_higher), .s_lower(s_lower),
    .ms_higher(ms_higher), .ms_lower(ms_lower),
    .running(running), .done(done), .expired(expired)
  );

  assign disp = {min_higher, min_lower, s_higher, s_lower, ms_higher, ms_lower};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] a, b, c, d);
    p_mh = a; p_ml = b; p_sh = c; p_sl = d;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    p_mh = 4'd0; p_ml = 4'd0; p_sh = 4'd0; p_sl = 4'd0;
    #3;
    chk("rst_disp", disp, 24'h000000);
    chk("rst_flags", {21'd0, running, done, expired}, 24'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1);

    // zero value: start ignored
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    do_start();
    chk("zero_start_run", 24'(running), 24'd0);
    cyc(1);
    chk("zero_start_disp", disp, 24'h000000);
    chk("zero_start_run2", 24'(running), 24'd0);

    // 00:01 full countdown
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    chk("load1_disp", disp, 24'h000100);
    do_start();
    chk("run1_flag", 24'(running), 24'd1);
    cyc(3);
    chk("run1_pre_tick", disp, 24'h000100);
    cyc(1);
    chk("run1_first_dec", disp, 24'h000099);
    cyc(395);
    chk("run1_last", disp, 24'h000001);
    chk("run1_nodone", 24'(done), 24'd0);
    stop = 1'b1;                  // stop collides with the expiring tick
    cyc(1);
    stop = 1'b0;
    chk("exp_disp", disp, 24'h000000);
    chk("exp_flags", {21'd0, running, done, expired}, 24'b011);
    cyc(1);
    chk("exp_done_off", {21'd0, running, done, expired}, 24'b001);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("exp_hold", {disp[20:0], expired}, {21'd0, 1'b1});
    end
    do_start();
    chk("exp_start_ign", {21'd0, running, done, expired}, 24'b001);

    // 10:00 borrow across all digits
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    chk("load10_disp", disp, 24'h100000);
    chk("load10_exp", 24'(expired), 24'd0);
    do_start();
    cyc(3);
    chk("b10_pre", disp, 24'h100000);
    cyc(1);
    chk("b10_borrow", disp, 24'h095999);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("b10_paused", 24'(running), 24'd0);

    // pause / resume at 00:05.00
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    chk("load5_disp", disp, 24'h000500);
    do_start();
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("p5_stop_run", 24'(running), 24'd0);
    cyc(50);
    chk("p5_frozen", disp, 24'h000500);
    do_start();
    chk("p5_resume_run", 24'(running), 24'd1);
    cyc(3);
    chk("p5_resume_pre", disp, 24'h000500);
    cyc(1);
    chk("p5_resume_dec", disp, 24'h000499);
    do_load(4'd0, 4'd0, 4'd0, 4'd9);
    chk("p5_load_ign", disp, 24'h000499);
    chk("p5_load_run", 24'(running), 24'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // saturating presets, start+stop together
    do_load(4'hF, 4'hF, 4'hF, 4'hF);
    chk("sat_disp", disp, 24'h595900);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_run", 24'(running), 24'd0);
    cyc(4);
    chk("ss_disp", disp, 24'h595900);

    // asynchronous reset mid-count
    do_start();
    cyc(4);
    chk("pre_rst_disp", disp, 24'h595899);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_disp", disp, 24'h000000);
    chk("arst_flags", {21'd0, running, done, expired}, 24'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_start();
    chk("post_rst_idle", 24'(running), 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: DELAY, default 500000, clock cycles per 10 ms tick (50 MHz clock); legal range 2..524287.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  single-cycle pulse; loads the preset digits.
REQ-005 start  input  1  single-cycle pulse; begins or resumes countdown.
REQ-006 stop  input  1  single-cycle pulse; pauses countdown.
REQ-007 preset_min_higher, preset_min_lower, preset_s_higher, preset_s_lower  input  4 each  BCD preset for MM:SS.
REQ-008 min_higher, min_lower, s_higher, s_lower, ms_higher, ms_lower  output  4 each  registered BCD remaining time; ms_* are tens and hundredths of seconds.
REQ-009 running  output  1  high while in RUNNING.
REQ-010 done  output  1  registered one-cycle pulse when the count reaches zero.
REQ-011 expired  output  1  high while in EXPIRED.

Function
REQ-012 States SHALL be IDLE, RUNNING, PAUSED and EXPIRED.
REQ-013 Digit ranges SHALL be: min_higher 0-5, min_lower 0-9, s_higher 0-5, s_lower 0-9, ms_higher 0-9, ms_lower 0-9; the maximum value is 59:59.99.
REQ-014 load SHALL be accepted in IDLE, PAUSED or EXPIRED. It copies the presets into the minute and second digits, clears ms_higher and ms_lower, and enters IDLE on the next edge.
REQ-015 load SHALL be ignored in RUNNING.
REQ-016 On load, any preset digit above its range maximum SHALL saturate to that maximum (9, or 5 for the higher digits).
REQ-017 start SHALL move IDLE or PAUSED to RUNNING only when the displayed value is non-zero, and SHALL clear the tick prescaler to 0.
REQ-018 start SHALL be ignored when the value is zero, in RUNNING, and in EXPIRED.
REQ-019 stop in RUNNING SHALL move to PAUSED and hold all digits and the prescaler; stop SHALL be ignored in all other states.
REQ-020 Same-cycle priority SHALL be: load over start; stop over start.
REQ-021 In RUNNING, the prescaler SHALL count 0..DELAY-1 and wrap to 0; a tick occurs in the cycle where the prescaler equals DELAY-1.
REQ-022 The first decrement SHALL therefore occur DELAY cycles after the start edge.
REQ-023 On each tick, the time SHALL decrement by 0.01 s as a BCD borrow chain: a digit at 0 reloads its range maximum and borrows from the next-higher digit; otherwise it decrements and no borrow propagates.
REQ-024 When a tick takes the value from 00:00.01 to 00:00.00, the block SHALL enter EXPIRED on that same edge and assert done for exactly that following cycle.
REQ-025 The digits SHALL never wrap below zero; no decrement occurs in any state other than RUNNING.
REQ-026 EXPIRED SHALL be left only through load or reset.
REQ-027 A stop in the same cycle as the expiring tick SHALL be ignored: EXPIRED wins and done still pulses.
REQ-028 running SHALL equal (state == RUNNING), and expired SHALL equal (state == EXPIRED), both registered.

Reset
REQ-029 While reset_n is low, all outputs SHALL be 0, the state SHALL be IDLE, and the prescaler SHALL be 0, immediately and without waiting for a clock edge.
REQ-030 After reset_n rises, the block SHALL respond to controls from the first clock edge; a reset mid-count abandons the count.

Verification (DELAY=4)
REQ-031 Load 00:00 then start -> start ignored; running=0; digits stay 00:00.00.
REQ-032 Load 00:01 then start -> first decrement to 00:00.99 four cycles after the start edge; after 100 ticks expired=1, done high for one cycle, digits 00:00.00, and 20 further idle cycles produce no change.
REQ-033 Load 10:00, start, one tick -> 09:59.99; this checks the borrow across all six digits.
REQ-034 Running at 00:05.00: stop -> digits frozen for 50 cycles; start -> countdown resumes, first decrement DELAY cycles later; load while running -> ignored.
REQ-035 Load presets F,F,F,F -> 59:59.00; start and stop in the same cycle -> remains IDLE.
REQ-036 reset_n pulsed low asynchronously mid-count, between clock edges -> all outputs 0 before the next edge; state IDLE.
